cksum_sched: RTL and testbench

Two-requester scheduler for the shared one's-complement checksum engine on the dibit (N-bit) Ethernet path. It arbitrates between two frame sources with a round-robin policy and forwards the owner's stream to the engine. It captures the 16-bit result and returns it to the owner with a done pulse. Between frames it resets the engine, and it aborts frames that break the engine's framing rules.

---
 rtl/cksum_sched.sv | 147 ++++++++++++++
 tb/tb_cksum_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cksum_sched.sv
// Round-robin scheduler that shares one one's-complement checksum engine between two
// frame sources: it forwards the owner's chunks, captures the result and clears the engine.
module cksum_sched #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req,
    input  logic [1:0]     valid,
    input  logic [2*N-1:0] data,
    input  logic [1:0]     last,
    output logic [1:0]     grant,
    output logic [1:0]     done,
    output logic [1:0]     err,
    output logic [15:0]    cksum,
    output logic           ck_rst,
    output logic           ck_axiiv,
    output logic [N-1:0]   ck_axiid,
    input  logic [15:0]    ck_axiod
);
    localparam int BEATS = 16 / N;
    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BC = BCW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, CAPTURE, CLEAR} state_t;

    state_t         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     done_q, done_d;
    logic [1:0]     err_q, err_d;
    logic [15:0]    cksum_q, cksum_d;
    logic           ck_rst_q, ck_rst_d;
    logic           ck_axiiv_q, ck_axiiv_d;
    logic [N-1:0]   ck_axiid_q, ck_axiid_d;
    logic           ptr_q, ptr_d;
    logic           owner_q, owner_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic           started_q, started_d;

    logic           own_valid;
    logic           own_last;
    logic [N-1:0]   own_data;
    logic [1:0]     owner_oh;

    assign own_valid = valid[owner_q];
    assign own_last  = last[owner_q];
    assign own_data  = owner_q ? data[2*N-1:N] : data[N-1:0];
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        cksum_d    = cksum_q;
        ck_rst_d   = 1'b0;
        ck_axiiv_d = 1'b0;
        ck_axiid_d = ck_axiid_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        bc_d       = bc_q;
        started_d  = started_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d   = (req == 2'b11) ? ptr_q : req[1];
                    grant_d   = owner_d ? 2'b10 : 2'b01;
                    bc_d      = '0;
                    started_d = 1'b0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (own_valid && !(own_last && bc_q != LAST_BC)) begin
                    ck_axiiv_d = 1'b1;
                    ck_axiid_d = own_data;
                    bc_d       = (bc_q == LAST_BC) ? '0 : bc_q + 1'b1;
                    started_d  = 1'b1;
                    if (own_last) begin
                        grant_d = 2'b00;
                        state_d = DRAIN;
                    end
                end else if (own_valid || started_q) begin
                    // Misaligned last, or a gap the engine would silently treat as a restart.
                    err_d    = owner_oh;
                    grant_d  = 2'b00;
                    ck_rst_d = 1'b1;
                    state_d  = CLEAR;
                end
            end
            DRAIN: state_d = CAPTURE;
            CAPTURE: begin
                cksum_d  = ck_axiod;
                done_d   = owner_oh;
                ck_rst_d = 1'b1;
                state_d  = CLEAR;
            end
            CLEAR: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            cksum_q    <= 16'h0000;
            ck_rst_q   <= 1'b1;
            ck_axiiv_q <= 1'b0;
            ck_axiid_q <= '0;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            bc_q       <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cksum_q    <= cksum_d;
            ck_rst_q   <= ck_rst_d;
            ck_axiiv_q <= ck_axiiv_d;
            ck_axiid_q <= ck_axiid_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            bc_q       <= bc_d;
            started_q  <= started_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cksum    = cksum_q;
    assign ck_rst   = ck_rst_q;
    assign ck_axiiv = ck_axiiv_q;
    assign ck_axiid = ck_axiid_q;

endmodule

// File: tb/tb_cksum_sched.sv
// Bench for cksum_sched: a behavioural checksum engine on the engine port, plus
// scenario tasks checked against an arithmetic checksum and a round-robin owner model.
module tb_cksum_sched;
    localparam int N = 2;
    localparam int BEATS = 16 / N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req, valid, last;
    logic [2*N-1:0] data;
    logic [1:0]     grant, done, err;
    logic [15:0]    cksum;
    logic           ck_rst, ck_axiiv;
    logic [N-1:0]   ck_axiid;
    logic [15:0]    ck_axiod;

    int total = 0;
    int bad = 0;
    int ptr_m = 0;
    logic [15:0] exp_cksum = 16'h0000;
    logic [15:0] wd [8];

    cksum_sched #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .valid(valid), .data(data), .last(last),
        .grant(grant), .done(done), .err(err), .cksum(cksum), .ck_rst(ck_rst),
        .ck_axiiv(ck_axiiv), .ck_axiid(ck_axiid), .ck_axiod(ck_axiod)
    );

    always #5 clk = ~clk;

    // Engine model: shifts chunks MSB-first, folds each full word in with end-around carry.
    logic [15:0] eng_sum, eng_word, eng_next;
    logic [16:0] eng_add;
    int          eng_cnt;
    assign eng_next = {eng_word[15-N:0], ck_axiid};
    assign eng_add  = {1'b0, eng_sum} + {1'b0, eng_next};
    assign ck_axiod = ~eng_sum;
    always @(posedge clk) begin
        if (ck_rst) begin
            eng_sum <= 16'h0000; eng_word <= 16'h0000; eng_cnt <= 0;
        end else if (ck_axiiv) begin
            eng_word <= eng_next;
            if (eng_cnt == BEATS - 1) begin
                eng_sum <= eng_add[15:0] + {15'b0, eng_add[16]};
                eng_cnt <= 0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end else if (eng_cnt != 0) begin
            eng_word <= 16'h0000; eng_cnt <= 0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] chunk_of(input logic [15:0] w, input int k);
        logic [15:0] s;
        s = w >> (16 - N * (k + 1));
        return s[N-1:0];
    endfunction

    function automatic logic [15:0] ref_cksum(input int nw);
        logic [31:0] s = 32'h0;
        for (int i = 0; i < nw; i++) begin
            s = s + {16'h0, wd[i]};
            s = (s & 32'hFFFF) + (s >> 16);
        end
        return ~s[15:0];
    endfunction

    function automatic int exp_owner(input logic [1:0] r);
        if (r == 2'b11) return ptr_m;
        return r[1] ? 1 : 0;
    endfunction

    task automatic noise(input int o);
        int x = 1 - o;
        valid[x] = 1'($urandom_range(0, 1));
        last[x]  = 1'($urandom_range(0, 1));
        data[N*x +: N] = N'($urandom);
    endtask

    task automatic send_chunk(input int o, input logic [N-1:0] c, input logic l);
        valid[o] = 1'b1;
        data[N*o +: N] = c;
        last[o] = l;
        noise(o);
        tick();
    endtask

    task automatic quiet();
        valid = 2'b00; last = 2'b00; data = '0;
    endtask

    // kind 0: full frame of nw words; 1: gap after cut chunks; 2: last on chunk index cut.
    task automatic run_frame(input int o, input int nw, input int wait_cyc, input int kind, input int cut);
        logic [1:0] oh;
        logic [N-1:0] c;
        int nch;
        oh = (o == 1) ? 2'b10 : 2'b01;
        tick();
        total++;
        if (grant !== oh) begin
            bad++; $display("FAIL grant_latency: got %b expected %b", grant, oh);
        end
        req[o] = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            valid[o] = 1'b0; noise(o); tick();
            total++;
            if (err !== 2'b00 || grant !== oh) begin
                bad++; $display("FAIL pre_chunk_wait: got err=%b grant=%b expected err=00 grant=%b", err, grant, oh);
            end
        end
        nch = (kind == 0) ? nw * BEATS : (kind == 1) ? cut : cut + 1;
        for (int k = 0; k < nch; k++) begin
            c = chunk_of(wd[k / BEATS], k % BEATS);
            send_chunk(o, c, (k == nch - 1) && (kind != 1));
            if (!(kind == 2 && k == nch - 1)) begin
                total++;
                if (ck_axiiv !== 1'b1 || ck_axiid !== c) begin
                    bad++; $display("FAIL chunk_fwd: got v=%b d=%h expected v=1 d=%h", ck_axiiv, ck_axiid, c);
                end
            end
        end
        if (kind == 0) begin
            total++;
            if (grant !== 2'b00) begin
                bad++; $display("FAIL grant_drop: got %b expected 00", grant);
            end
            quiet(); tick();
            total++;
            if (ck_axiiv !== 1'b0 || done !== 2'b00) begin
                bad++; $display("FAIL drain: got v=%b done=%b expected v=0 done=00", ck_axiiv, done);
            end
            tick();
            exp_cksum = ref_cksum(nw);
            total++;
            if (done !== oh || ck_rst !== 1'b1 || err !== 2'b00 || cksum !== exp_cksum) begin
                bad++;
                $display("FAIL done_pulse: got done=%b rst=%b err=%b ck=%h expected done=%b rst=1 err=00 ck=%h",
                         done, ck_rst, err, cksum, oh, exp_cksum);
            end
        end else begin
            if (kind == 1) begin
                quiet(); tick();
            end
            total++;
            if (err !== oh || ck_rst !== 1'b1 || grant !== 2'b00 || done !== 2'b00 || ck_axiiv !== 1'b0) begin
                bad++;
                $display("FAIL abort: got err=%b rst=%b grant=%b done=%b v=%b expected err=%b rst=1 grant=00 done=00 v=0",
                         err, ck_rst, grant, done, ck_axiiv, oh);
            end
            quiet();
        end
        tick();
        total++;
        if (done !== 2'b00 || err !== 2'b00 || ck_rst !== 1'b0 || cksum !== exp_cksum) begin
            bad++;
            $display("FAIL post_frame: got done=%b err=%b rst=%b ck=%h expected 00 00 0 ck=%h",
                     done, err, ck_rst, cksum, exp_cksum);
        end
        ptr_m = 1 - o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00; quiet();
        repeat (2) tick();
        total++;
        if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00 || cksum !== 16'h0 ||
            ck_axiiv !== 1'b0 || ck_axiid !== '0 || ck_rst !== 1'b1) begin
            bad++; $display("FAIL reset_values: got g=%b d=%b e=%b ck=%h v=%b rst=%b", grant, done, err, cksum, ck_axiiv, ck_rst);
        end
        #2 rst_n = 1'b1;
        tick();
        total++;
        if (ck_rst !== 1'b0) begin
            bad++; $display("FAIL reset_release: got ck_rst=%b expected 0", ck_rst);
        end
        ptr_m = 0; exp_cksum = 16'h0;
    endtask

    task automatic test_contention();
        for (int f = 0; f < 4; f++) begin
            wd[0] = 16'($urandom);
            req = 2'b11;
            run_frame(exp_owner(req), 1, 0, 0, 0);
        end
        req = 2'b00;
    endtask

    task automatic test_single_frame();
        wd[0] = 16'h4500; wd[1] = 16'h0030;
        req = 2'b01;
        run_frame(0, 2, 0, 0, 0);
        total++;
        if (cksum !== 16'hBACF) begin
            bad++; $display("FAIL single_frame: got %h expected BACF", cksum);
        end
    endtask

    task automatic test_carry_wrap();
        wd[0] = 16'hFFFF; wd[1] = 16'h0001;
        req = 2'b10;
        run_frame(1, 2, 1, 0, 0);
        total++;
        if (cksum !== 16'hFFFE) begin
            bad++; $display("FAIL carry_wrap: got %h expected FFFE", cksum);
        end
        wd[0] = 16'h0000;
        req = 2'b01;
        run_frame(0, 1, 0, 0, 0);
        total++;
        if (cksum !== 16'hFFFF) begin
            bad++; $display("FAIL zero_word: got %h expected FFFF", cksum);
        end
    endtask

    task automatic test_gap_abort();
        wd[0] = 16'h1234; wd[1] = 16'h5678;
        req = 2'b10;
        run_frame(1, 2, 0, 1, 3);
        wd[0] = 16'hABCD;
        req = 2'b11;
        run_frame(exp_owner(req), 1, 0, 0, 0);
        req = 2'b00;
    endtask

    task automatic test_misaligned();
        wd[0] = 16'hC3A5;
        req = 2'b01;
        run_frame(0, 1, 0, 2, 4);
    endtask

    task automatic test_async_reset();
        wd[0] = 16'h9A7E;
        req = 2'b01;
        tick(); req = 2'b00;
        for (int k = 0; k < 3; k++) send_chunk(0, chunk_of(wd[0], k), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00 || cksum !== 16'h0 ||
            ck_axiiv !== 1'b0 || ck_axiid !== '0 || ck_rst !== 1'b1) begin
            bad++; $display("FAIL async_reset: got g=%b d=%b e=%b ck=%h v=%b rst=%b", grant, done, err, cksum, ck_axiiv, ck_rst);
        end
        #1 rst_n = 1'b1;
        quiet(); tick();
        ptr_m = 0; exp_cksum = 16'h0;
        total++;
        if (ck_rst !== 1'b0 || done !== 2'b00 || err !== 2'b00 || grant !== 2'b00) begin
            bad++; $display("FAIL async_release: got rst=%b done=%b err=%b grant=%b", ck_rst, done, err, grant);
        end
        wd[0] = 16'h0F0F; wd[1] = 16'hF00F;
        req = 2'b11;
        run_frame(exp_owner(req), 2, 0, 0, 0);
        req = 2'b00;
    endtask

    task automatic test_random();
        int kind, nw, cut;
        for (int f = 0; f < 16; f++) begin
            nw = $urandom_range(1, 3);
            for (int i = 0; i < nw; i++) wd[i] = 16'($urandom);
            kind = $urandom_range(0, 4);
            if (kind > 2) kind = 0;
            cut = 0;
            if (kind == 1) cut = $urandom_range(1, nw * BEATS - 1);
            if (kind == 2) cut = $urandom_range(0, nw - 1) * BEATS + $urandom_range(0, BEATS - 2);
            req = 2'($urandom_range(1, 3));
            run_frame(exp_owner(req), nw, $urandom_range(0, 2), kind, cut);
            req = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_frame();
        test_carry_wrap();
        test_gap_abort();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
